// File: rtl/stream_mux_nx1.sv
// -----------------------------------------------------------------------------
// stream_mux_nx1
// N-to-1 valid/ready stream multiplexer with a single registered output slot.
//
// Build option:
//   MUX_RR_EN  - when defined, adds the rr_mode port, the round-robin pointer
//                register and the round-robin arbiter. When undefined, the
//                block is a fixed-select mux driven by sel only.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - NUM_CH packed channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (only the granted channel, only when slot free)
//   sel        - fixed-mode channel select (>= NUM_CH grants nothing)
//   rr_mode    - 1 = round-robin, 0 = fixed select (MUX_RR_EN only)
//   out_data   - registered output data
//   out_valid  - output valid
//   out_ready  - downstream ready
//   out_ch     - source channel index of out_data
// -----------------------------------------------------------------------------
module stream_mux_nx1 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [SEL_WIDTH-1:0]         sel,
`ifdef MUX_RR_EN
    input  logic                         rr_mode,
`endif
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_WIDTH-1:0]         out_ch
);

    localparam int unsigned PTR_W = $clog2(NUM_CH);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_WIDTH-1:0]  out_ch_q,    out_ch_d;

    logic                  slot_free_c;
    logic                  gnt_valid_c;
    logic [SEL_WIDTH-1:0]  gnt_idx_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] gnt_data_c;

    // The slot can take a new beat when empty or when its beat leaves this cycle.
    assign slot_free_c = !out_valid_q || out_ready;

`ifdef MUX_RR_EN
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 rr_hi_found_c, rr_lo_found_c;
    logic [SEL_WIDTH-1:0] rr_hi_idx_c,   rr_lo_idx_c;

    // Round-robin search: lowest valid channel at or above ptr wins; if none,
    // wrap to the lowest valid channel overall. Scanning downward lets the
    // last hit be the lowest index.
    always_comb begin : rr_search
        rr_hi_found_c = 1'b0;
        rr_lo_found_c = 1'b0;
        rr_hi_idx_c   = '0;
        rr_lo_idx_c   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_lo_found_c = 1'b1;
                rr_lo_idx_c   = SEL_WIDTH'(i);
                if (32'(i) >= 32'(ptr_q)) begin
                    rr_hi_found_c = 1'b1;
                    rr_hi_idx_c   = SEL_WIDTH'(i);
                end
            end
        end
    end
`endif

    // Grant decision for the current cycle.
    always_comb begin : grant
        gnt_valid_c = 1'b0;
        gnt_idx_c   = sel;
`ifdef MUX_RR_EN
        if (rr_mode) begin
            gnt_valid_c = rr_hi_found_c || rr_lo_found_c;
            gnt_idx_c   = rr_hi_found_c ? rr_hi_idx_c : rr_lo_idx_c;
        end else
`endif
        begin
            gnt_valid_c = (32'(sel) < NUM_CH);
            gnt_idx_c   = sel;
        end
    end

    // One-hot ready to the granted channel; forced low while in reset.
    always_comb begin : ready_gen
        in_ready = '0;
        if (rst_n && gnt_valid_c && slot_free_c) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                in_ready[i] = (gnt_idx_c == SEL_WIDTH'(i));
            end
        end
    end

    assign accept_c = |(in_ready & in_valid);

    // Data select for the granted channel.
    always_comb begin : data_mux
        gnt_data_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx_c == SEL_WIDTH'(i)) begin
                gnt_data_c = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output slot next state: load on accept, drain on output transfer, else hold.
    always_comb begin : slot_next
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data_c;
            out_ch_d    = gnt_idx_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : slot_reg
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef MUX_RR_EN
    // Pointer moves just past the channel whose beat was accepted.
    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (accept_c) begin
            if (32'(gnt_idx_c) == NUM_CH - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = PTR_W'(gnt_idx_c) + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_nx1
// Directed and randomized checks of stream_mux_nx1 against a behavioural model.
// Round-robin scenarios are compiled only when MUX_RR_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_mux_nx1;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned SW = 3;

    logic              clk;
    logic              rst_n;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [SW-1:0]     sel;
    logic              rr_mode;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_ch;

    int n_checks;
    int n_errors;

    // Reference model state: one slot plus the round-robin pointer.
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;

    stream_mux_nx1 #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
`ifdef MUX_RR_EN
        .rr_mode   (rr_mode),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the specification would grant right now, -1 for none.
    function automatic int model_grant();
        if (rr_mode) begin
            for (int k = 0; k < int'(NC); k++) begin
                int c;
                c = (m_ptr + k) % int'(NC);
                if (in_valid[c]) return c;
            end
            return -1;
        end
        if (int'(sel) < int'(NC)) return int'(sel);
        return -1;
    endfunction

    function automatic logic [NC-1:0] model_ready();
        int g;
        logic [NC-1:0] r;
        r = '0;
        g = model_grant();
        if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // One clock: check ready mid-cycle, advance the model at the edge,
    // check the slot just after the edge.
    task automatic step();
        int g;
        logic [NC-1:0] exp_rdy;
        logic          fire;
        @(negedge clk);
        exp_rdy = model_ready();
        g       = model_grant();
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        fire = (g >= 0) && exp_rdy[g] && in_valid[g];
        @(posedge clk);
        if (fire) begin
            m_valid = 1'b1;
            m_data  = in_data[g*DW +: DW];
            m_ch    = g;
            m_ptr   = (g + 1) % int'(NC);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_ch", 32'(out_ch), 32'(m_ch));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_data"},  32'(out_data),  32'(0));
        check({tag, "_ch"},    32'(out_ch),    32'(0));
        check({tag, "_ready"}, 32'(in_ready),  32'(0));
    endtask

    task automatic set_all_data(input logic [DW-1:0] base);
        for (int i = 0; i < int'(NC); i++) in_data[i*DW +: DW] = base + DW'(i);
    endtask

    initial begin
        logic [DW-1:0] held;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '1;
        sel       = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b1;
        model_reset();

        // Reset state, with traffic offered on every input.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed mode, sel=2, all valid: ch2 granted, 0xA5 out one cycle later.
        sel = 3'd2;
        set_all_data(8'h10);
        in_data[2*DW +: DW] = 8'hA5;
        step();
        check("fixed_ch", 32'(out_ch), 32'(2));
        check("fixed_data", 32'(out_data), 32'hA5);

        // Stall three cycles: slot holds, nothing accepted.
        out_ready = 1'b0;
        in_data[2*DW +: DW] = 8'h3C;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", 32'(out_data), 32'(held));
            check("stall_rdy", 32'(in_ready), 32'(0));
        end
        // Release: next beat loads on the same edge the held one leaves.
        out_ready = 1'b1;
        step();
        check("nobubble_valid", 32'(out_valid), 32'(1));
        check("nobubble_data", 32'(out_data), 32'h3C);

        // Out-of-range select grants nothing.
        sel = 3'd5;
        step();
        step();
        check("sel5_valid", 32'(out_valid), 32'(0));
        check("sel5_rdy", 32'(in_ready), 32'(0));

        // Fixed mode keeps granting a non-valid selected channel; no transfer.
        sel = 3'd1;
        in_valid = 4'b1101;
        step();
        step();

`ifdef MUX_RR_EN
        // Round-robin from a fresh reset: 0,1,2,3,0,1,2,3.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        rr_mode  = 1'b1;
        in_valid = '1;
        set_all_data(8'h40);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_seq", 32'(out_ch), 32'(i % 4));
        end

        // Drive ptr to 3 via ch2, then only ch1 valid: wrap grants ch1, ptr -> 2.
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0010;
        step();
        check("rr_wrap_ch", 32'(out_ch), 32'(1));
        in_valid = 4'b1110;
        step();
        check("rr_ptr2", 32'(out_ch), 32'(2));

        // Reset mid-stream with a beat held: cleared immediately.
        out_ready = 1'b0;
        in_valid  = '1;
        step();
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_ch", 32'(out_ch), 32'(0));
        check("post_rst_valid", 32'(out_valid), 32'(1));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = NC'($urandom);
            in_data   = (NC*DW)'({$urandom, $urandom});
            sel       = SW'($urandom_range(0, 7));
            out_ready = ($urandom % 4) != 0;
`ifdef MUX_RR_EN
            if ($urandom % 16 == 0) rr_mode = ~rr_mode;
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
